// File: rtl/alu_seq_core.sv
// alu_seq_core: WIDTH-bit valid/ready ALU with a one-entry registered result
// and an iterative shift-add signed multiplier.
module alu_seq_core #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_m,
   input  logic [WIDTH-1:0] in_n,
   input  logic             in_c,
   input  logic [3:0]       opc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_f,
   output logic             zer,
   output logic             neg,
   output logic             cout,
   output logic             ovf,
   output logic             err
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [3:0] OP_ADC    = 4'd0;
   localparam logic [3:0] OP_ADDH   = 4'd1;
   localparam logic [3:0] OP_MAX    = 4'd2;
   localparam logic [3:0] OP_TRIPLE = 4'd3;
   localparam logic [3:0] OP_AND    = 4'd4;
   localparam logic [3:0] OP_OR     = 4'd5;
   localparam logic [3:0] OP_NOTM   = 4'd6;
   localparam logic [3:0] OP_SUB    = 4'd7;
   localparam logic [3:0] OP_MIN    = 4'd8;
   localparam logic [3:0] OP_MUL    = 4'd9;
   localparam logic [3:0] OP_XOR    = 4'd10;

   typedef enum logic {ST_IDLE, ST_MUL} state_e;
   state_e state_q, state_d;

   logic [CW-1:0]        cnt_q;
   logic [2*WIDTH-1:0]   acc_q;
   logic [WIDTH-1:0]     mcand_q;
   logic                 psign_q;

   logic accept, mul_start, mul_done;
   assign in_ready  = rst_n && (state_q == ST_IDLE) && (!out_valid || out_ready);
   assign accept    = in_valid && in_ready;
   assign mul_start = accept && (opc == OP_MUL);
   assign mul_done  = (state_q == ST_MUL) && (cnt_q == CNT_LAST);

   logic [WIDTH-1:0] add_b;
   logic             add_ci;
   logic [WIDTH:0]   sum;
   logic             add_ovf, m_lt_n;

   // NOTE: every always_comb output is given a default first so no path leaves it unassigned and infers a latch.
   always_comb begin
      add_b  = in_n;
      add_ci = 1'b0;
      case (opc)
         OP_ADC:                 add_ci = in_c;
         OP_ADDH:                add_b  = $signed(in_n) >>> 1;
         OP_TRIPLE:              add_b  = {in_m[WIDTH-2:0], 1'b0};
         OP_SUB, OP_MAX, OP_MIN: begin
            add_b  = ~in_n;
            add_ci = 1'b1;
         end
         default: ;
      endcase
   end

   assign sum     = {1'b0, in_m} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_ci};
   assign add_ovf = (in_m[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != in_m[WIDTH-1]);
   // Differing signs decide the order directly, so a wrapped M-N is never consulted.
   assign m_lt_n  = (in_m[WIDTH-1] != in_n[WIDTH-1]) ? in_m[WIDTH-1] : sum[WIDTH-1];

   logic [WIDTH-1:0] res_f;
   logic             res_cout, res_ovf, res_err;

   always_comb begin
      res_f    = '0;
      res_cout = 1'b0;
      res_ovf  = 1'b0;
      res_err  = 1'b0;
      case (opc)
         OP_ADC, OP_ADDH, OP_SUB: begin
            res_f    = sum[WIDTH-1:0];
            res_cout = sum[WIDTH];
            res_ovf  = add_ovf;
         end
         OP_TRIPLE: begin
            res_f    = sum[WIDTH-1:0];
            res_cout = sum[WIDTH];
            res_ovf  = add_ovf || (in_m[WIDTH-1] != in_m[WIDTH-2]);
         end
         OP_MAX:  res_f = m_lt_n ? in_n : in_m;
         OP_MIN:  res_f = m_lt_n ? in_m : in_n;
         OP_AND:  res_f = in_m & in_n;
         OP_OR:   res_f = in_m | in_n;
         OP_NOTM: res_f = ~in_m;
         OP_XOR:  res_f = in_m ^ in_n;
         OP_MUL:  ;
         default: res_err = 1'b1;
      endcase
   end

   // Multiplier magnitudes; |min| fits as an unsigned WIDTH-bit value.
   logic [WIDTH-1:0]   mag_m, mag_n;
   logic [WIDTH:0]     part;
   logic [2*WIDTH-1:0] acc_step, prod;
   logic               mul_ovf;

   assign mag_m    = in_m[WIDTH-1] ? -in_m : in_m;
   assign mag_n    = in_n[WIDTH-1] ? -in_n : in_n;
   assign part     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
   assign acc_step = {part, acc_q[WIDTH-1:1]};
   assign prod     = psign_q ? -acc_step : acc_step;
   assign mul_ovf  = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (mul_start) state_d = ST_MUL;
         ST_MUL:  if (mul_done)  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         mcand_q   <= '0;
         psign_q   <= 1'b0;
         out_valid <= 1'b0;
         out_f     <= '0;
         zer       <= 1'b0;
         neg       <= 1'b0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
         err       <= 1'b0;
      end else begin
         state_q <= state_d;
         if (mul_start) begin
            acc_q   <= {{WIDTH{1'b0}}, mag_n};
            mcand_q <= mag_m;
            psign_q <= in_m[WIDTH-1] ^ in_n[WIDTH-1];
            cnt_q   <= '0;
         end else if (state_q == ST_MUL) begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + CW'(1);
         end

         if (accept && !mul_start) begin
            out_valid <= 1'b1;
            out_f     <= res_f;
            zer       <= (res_f == '0);
            neg       <= res_f[WIDTH-1];
            cout      <= res_cout;
            ovf       <= res_ovf;
            err       <= res_err;
         end else if (mul_done) begin
            out_valid <= 1'b1;
            out_f     <= prod[WIDTH-1:0];
            zer       <= (prod[WIDTH-1:0] == '0);
            neg       <= prod[WIDTH-1];
            cout      <= 1'b0;
            ovf       <= mul_ovf;
            err       <= 1'b0;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_alu_seq_core.sv
// Self-checking bench for alu_seq_core: directed WIDTH=16 steps plus a random
// single-cycle stream applied to WIDTH=8/16/32 instances, scoreboarded per instance.
module tb_alu_seq_core;
   localparam int WS [3] = '{8, 16, 32};

   typedef struct packed {
      logic [4:0]  fl;   // {zer, neg, cout, ovf, err}
      logic [63:0] f;
   } exp_t;

   typedef struct {
      logic [3:0]  op;
      logic [15:0] a, b;
      logic        ci;
      logic [15:0] f;
      logic [4:0]  fl;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, out_ready, c;
   logic [3:0]  opc;
   logic [63:0] m, n;

   logic        rdy [3];
   logic        ov  [3];
   logic [63:0] of  [3];
   logic [4:0]  fl  [3];

   int total = 0;
   int bad   = 0;
   exp_t sb [3][$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int WV = (g == 0) ? 8 : (g == 1) ? 16 : 32;
      logic [WV-1:0] f;
      logic          z, ng, co, ovf_o, er, rd, vo;
      alu_seq_core #(.WIDTH(WV)) dut (
         .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rd),
         .in_m(m[WV-1:0]), .in_n(n[WV-1:0]), .in_c(c), .opc(opc),
         .out_valid(vo), .out_ready(out_ready), .out_f(f),
         .zer(z), .neg(ng), .cout(co), .ovf(ovf_o), .err(er)
      );
      assign rdy[g] = rd;
      assign ov[g]  = vo;
      assign of[g]  = 64'(f);
      assign fl[g]  = {z, ng, co, ovf_o, er};
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic oor(input longint v, input int w);
      longint hi;
      hi = (longint'(1) << (w - 1)) - 1;
      return (v > hi) || (v < -hi - 1);
   endfunction

   // Reference model written in integer arithmetic on sign-extended operands.
   function automatic exp_t model(input int w, input logic [3:0] op,
                                  input logic [63:0] a, input logic [63:0] b, input logic ci);
      logic [63:0] mask, ua, ub, full;
      longint      sa, sb_v, t;
      exp_t        e;
      mask = (64'd1 << w) - 64'd1;
      ua   = a & mask;
      ub   = b & mask;
      sa   = $signed(ua << (64 - w)) >>> (64 - w);
      sb_v = $signed(ub << (64 - w)) >>> (64 - w);
      e    = '0;
      case (op)
         4'd0: begin
            full = ua + ub + 64'(ci);
            e.f = full & mask; e.fl[2] = full[w]; e.fl[1] = oor(sa + sb_v + longint'(ci), w);
         end
         4'd1: begin
            t = sb_v >>> 1;
            full = ua + (64'(t) & mask);
            e.f = full & mask; e.fl[2] = full[w]; e.fl[1] = oor(sa + t, w);
         end
         4'd2: e.f = (sa >= sb_v) ? ua : ub;
         4'd3: begin
            full = ua + ((ua << 1) & mask);
            e.f = full & mask; e.fl[2] = full[w]; e.fl[1] = oor(2 * sa, w) || oor(3 * sa, w);
         end
         4'd4: e.f = ua & ub;
         4'd5: e.f = ua | ub;
         4'd6: e.f = ~ua & mask;
         4'd7: begin
            full = ua + (~ub & mask) + 64'd1;
            e.f = full & mask; e.fl[2] = full[w]; e.fl[1] = oor(sa - sb_v, w);
         end
         4'd8: e.f = (sa <= sb_v) ? ua : ub;
         4'd9: begin
            t = sa * sb_v;
            e.f = 64'(t) & mask; e.fl[1] = oor(t, w);
         end
         4'd10: e.f = ua ^ ub;
         default: e.fl[0] = 1'b1;
      endcase
      e.fl[4] = (e.f == 64'd0);
      e.fl[3] = e.f[w-1];
      return e;
   endfunction

   // Scoreboard: push on accept, pop and compare on drain.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         for (int k = 0; k < 3; k++) sb[k].delete();
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (ov[k] && out_ready) begin
               if (sb[k].size() == 0) begin
                  check($sformatf("w%0d_stray_result", WS[k]), 64'(ov[k]), 64'd0);
               end else begin
                  e = sb[k].pop_front();
                  check($sformatf("w%0d_out_f", WS[k]), of[k], e.f);
                  check($sformatf("w%0d_flags", WS[k]), 64'(fl[k]), 64'(e.fl));
               end
            end
            if (in_valid && rdy[k]) sb[k].push_back(model(WS[k], opc, m, n, c));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b, input logic ci);
      opc = o; m = a; n = b; c = ci; in_valid = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "bench timed out");
   end

   initial begin
      vec_t vt [7];
      int   cnt;
      logic saw;
      vt[0] = '{4'd0,  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 5'b01010};
      vt[1] = '{4'd7,  16'h0003, 16'h0005, 1'b0, 16'hFFFE, 5'b01000};
      vt[2] = '{4'd2,  16'h7000, 16'h9000, 1'b0, 16'h7000, 5'b00000};
      vt[3] = '{4'd8,  16'h7000, 16'h9000, 1'b0, 16'h9000, 5'b01000};
      vt[4] = '{4'd2,  16'hFFFD, 16'h0005, 1'b0, 16'h0005, 5'b00000};
      vt[5] = '{4'd2,  16'h1234, 16'h1234, 1'b0, 16'h1234, 5'b00000};
      vt[6] = '{4'd15, 16'h1234, 16'h5678, 1'b1, 16'h0000, 5'b10001};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      opc = 4'd0; m = '0; n = '0; c = 1'b0;
      repeat (3) tick();
      check("rst_out_valid", 64'(ov[1]), 64'd0);
      check("rst_out_f", of[1], 64'd0);
      check("rst_flags", 64'(fl[1]), 64'd0);
      check("rst_in_ready_low", 64'(rdy[1]), 64'd0);
      rst_n = 1'b1;
      #1;
      check("rst_release_in_ready", 64'(rdy[1]), 64'd1);

      // Directed single-cycle ops streamed back to back
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         drive(vt[i].op, 64'(vt[i].a), 64'(vt[i].b), vt[i].ci);
         tick();
         check($sformatf("vec%0d_valid", i), 64'(ov[1]), 64'd1);
         check($sformatf("vec%0d_f", i), of[1], 64'(vt[i].f));
         check($sformatf("vec%0d_flags", i), 64'(fl[1]), 64'(vt[i].fl));
      end
      in_valid = 1'b0;
      tick();

      // Reset in the middle of a multiply
      drive(4'd9, 64'hFFF9, 64'd300, 1'b0);
      tick();
      in_valid = 1'b0;
      repeat (5) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      check("midmul_rst_valid", 64'(ov[1]), 64'd0);
      check("midmul_rst_f", of[1], 64'd0);
      check("midmul_rst_flags", 64'(fl[1]), 64'd0);
      tick();
      check("midmul_rst_in_ready", 64'(rdy[1]), 64'd1);
      saw = 1'b0;
      repeat (20) begin
         tick();
         if (ov[1]) saw = 1'b1;
      end
      check("midmul_no_stray", 64'(saw), 64'd0);

      // MUL -7 * 300, with ignored traffic while busy
      drive(4'd9, 64'hFFF9, 64'd300, 1'b0);
      tick();
      check("mul1_busy_ready", 64'(rdy[1]), 64'd0);
      drive(4'd4, 64'h5555, 64'h3333, 1'b0);
      for (int i = 1; i <= 15; i++) begin
         tick();
         check($sformatf("mul1_wait%0d_valid", i), 64'(ov[1]), 64'd0);
         check($sformatf("mul1_wait%0d_ready", i), 64'(rdy[1]), 64'd0);
      end
      in_valid = 1'b0;
      tick();
      check("mul1_valid", 64'(ov[1]), 64'd1);
      check("mul1_f", of[1], 64'hF7CC);
      check("mul1_flags", 64'(fl[1]), 64'(5'b01000));

      // MUL overflow into zero
      drive(4'd9, 64'h4000, 64'd4, 1'b0);
      tick();
      in_valid = 1'b0;
      cnt = 0;
      while (!ov[1] && cnt < 40) begin
         tick();
         cnt++;
      end
      check("mul2_latency", 64'(cnt), 64'd16);
      check("mul2_f", of[1], 64'h0000);
      check("mul2_flags", 64'(fl[1]), 64'(5'b10010));

      // Backpressure: AND held, XOR queued then taken on the drain edge
      drive(4'd4, 64'hF0F0, 64'hFF00, 1'b0);
      tick();
      out_ready = 1'b0;
      check("bp_and_f", of[1], 64'hF000);
      drive(4'd10, 64'hFFFF, 64'hF00F, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("bp_hold%0d_f", i), of[1], 64'hF000);
         check($sformatf("bp_hold%0d_ready", i), 64'(rdy[1]), 64'd0);
         check($sformatf("bp_hold%0d_valid", i), 64'(ov[1]), 64'd1);
      end
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check("bp_xor_valid", 64'(ov[1]), 64'd1);
      check("bp_xor_f", of[1], 64'h0FF0);
      tick();

      // Resynchronise all widths, then a random single-cycle stream
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         logic [3:0] o;
         o = 4'($urandom_range(0, 15));
         if (o == 4'd9) o = 4'd10;
         drive(o, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
         tick();
         for (int k = 0; k < 3; k++)
            check($sformatf("w%0d_stream%0d_valid", WS[k], i), 64'(ov[k]), 64'd1);
      end
      in_valid = 1'b0;
      repeat (3) tick();
      for (int k = 0; k < 3; k++)
         check($sformatf("w%0d_sb_empty", WS[k]), 64'(sb[k].size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
